// File: rtl/ram_arbiter_2p.sv
// Round-robin arbiter/sequencer sharing one single-port RAM between two requesters.
// Registers every RAM command and returns read data to the issuing port two cycles after acceptance.
module ram_arbiter_2p #(
    parameter int RAM_WIDTH = 22,
    parameter int RAM_DEPTH = 1024,
    parameter int ADDR_SIZE = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [ADDR_SIZE-1:0] a_addr,
    input  logic [RAM_WIDTH-1:0] a_wdata,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [ADDR_SIZE-1:0] b_addr,
    input  logic [RAM_WIDTH-1:0] b_wdata,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [RAM_WIDTH-1:0] rdata,
    output logic                 rerr,
    output logic                 err_pulse,
    output logic                 ram_wr_enb,
    output logic                 ram_rd_enb,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [RAM_WIDTH-1:0] ram_data_in,
    input  logic [RAM_WIDTH-1:0] ram_data_out
);

    // Handshake: a port's command is transferred at the rising edge where req and gnt are both 1;
    // the requester holds we/addr/wdata stable from req rising until that edge.

    logic                 last_gnt_b;   // 1 = port B owned the most recent accepted transfer
    logic                 accept;
    logic                 sel_we;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [RAM_WIDTH-1:0] sel_wdata;
    logic [31:0]          sel_addr_ext;
    logic                 illegal;

    logic s1_valid, s1_port_b, s1_illegal;
    logic s2_valid, s2_port_b, s2_illegal;

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (rst_n) begin
            if (a_req && (!b_req || last_gnt_b)) begin
                a_gnt = 1'b1;
            end else if (b_req) begin
                b_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        accept       = a_gnt | b_gnt;
        sel_we       = b_gnt ? b_we    : a_we;
        sel_addr     = b_gnt ? b_addr  : a_addr;
        sel_wdata    = b_gnt ? b_wdata : a_wdata;
        sel_addr_ext = 32'(sel_addr);
        illegal      = (sel_addr_ext >= 32'(RAM_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_b  <= 1'b1;
            ram_wr_enb  <= 1'b0;
            ram_rd_enb  <= 1'b0;
            err_pulse   <= 1'b0;
            ram_addr    <= '0;
            ram_data_in <= '0;
        end else begin
            ram_wr_enb <= accept & sel_we & ~illegal;
            ram_rd_enb <= accept & ~sel_we & ~illegal;
            err_pulse  <= accept & illegal;
            if (accept) begin
                last_gnt_b <= b_gnt;
            end
            // Illegal transfers never touch the RAM bus, so address/data keep their last values.
            if (accept && !illegal) begin
                ram_addr <= sel_addr;
            end
            if (accept && sel_we && !illegal) begin
                ram_data_in <= sel_wdata;
            end
        end
    end

    // Stage 1 lines up with the RAM command, stage 2 with the RAM output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_port_b  <= 1'b0;
            s1_illegal <= 1'b0;
            s2_valid   <= 1'b0;
            s2_port_b  <= 1'b0;
            s2_illegal <= 1'b0;
        end else begin
            s1_valid   <= accept & ~sel_we;
            s1_port_b  <= b_gnt;
            s1_illegal <= illegal;
            s2_valid   <= s1_valid;
            s2_port_b  <= s1_port_b;
            s2_illegal <= s1_illegal;
        end
    end

    always_comb begin
        a_rvalid = s2_valid & ~s2_port_b;
        b_rvalid = s2_valid & s2_port_b;
        rerr     = s2_valid & s2_illegal;
        rdata    = (s2_valid && !s2_illegal) ? ram_data_out : '0;
    end

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Self-checking bench for ram_arbiter_2p: directed scenarios followed by random two-port traffic,
// checked against a transaction-level model of grants, RAM contents and response timing.
module tb_ram_arbiter_2p;

    localparam int W     = 22;
    localparam int AW    = 11;
    localparam int DEPTH = 1024;
    localparam int RW    = W + 3;   // response entry: {a_rvalid, b_rvalid, rerr, rdata}

    logic          clk;
    logic          rst_n;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [W-1:0]  a_wdata, b_wdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid, rerr, err_pulse;
    logic          ram_wr_enb, ram_rd_enb;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_data_in, ram_data_out, rdata;

    int checks = 0;
    int errors = 0;

    ram_arbiter_2p #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .ADDR_SIZE(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid),
        .rdata(rdata), .rerr(rerr), .err_pulse(err_pulse),
        .ram_wr_enb(ram_wr_enb), .ram_rd_enb(ram_rd_enb),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    // ---------------- clock / RAM behavioural model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_wr_enb) mem[ram_addr[9:0]] <= ram_data_in;
        if (ram_rd_enb) ram_data_out <= mem[ram_addr[9:0]];
    end

    // ---------------- reference model state ----------------
    logic [W-1:0]  ref_mem [0:DEPTH-1];
    logic [RW-1:0] exp_q[$];
    bit            m_last_b;
    bit            m_wr, m_rd, m_err;
    logic [AW-1:0] m_addr;
    logic [W-1:0]  m_din;
    bit            m_ga, m_gb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last_b = 1'b1;
        m_wr = 1'b0; m_rd = 1'b0; m_err = 1'b0;
        m_addr = '0; m_din = '0;
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_gnt"},    32'(a_gnt), 0);
        check({tag, "_b_gnt"},    32'(b_gnt), 0);
        check({tag, "_a_rvalid"}, 32'(a_rvalid), 0);
        check({tag, "_b_rvalid"}, 32'(b_rvalid), 0);
        check({tag, "_rerr"},     32'(rerr), 0);
        check({tag, "_rdata"},    32'(rdata), 0);
        check({tag, "_err"},      32'(err_pulse), 0);
        check({tag, "_wr_enb"},   32'(ram_wr_enb), 0);
        check({tag, "_rd_enb"},   32'(ram_rd_enb), 0);
        check({tag, "_addr"},     32'(ram_addr), 0);
        check({tag, "_din"},      32'(ram_data_in), 0);
    endtask

    // ---------------- driver: one clock cycle of stimulus + checks ----------------
    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input bit ar, input bit aw, input logic [AW-1:0] aa, input logic [W-1:0] ad,
                         input bit br, input bit bw, input logic [AW-1:0] ba, input logic [W-1:0] bd,
                         output bit obs_a, output bit obs_b);
        logic [RW-1:0] resp;
        logic [RW-1:0] entry;
        bit            p_we;
        logic [AW-1:0] p_addr;
        logic [W-1:0]  p_wd;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        #1;
        // Round robin: a lone requester wins; under contention the port not served last wins.
        m_ga = ar && (!br || m_last_b);
        m_gb = br && !m_ga;
        obs_a = a_gnt;
        obs_b = b_gnt;
        check("a_gnt", 32'(a_gnt), 32'(m_ga));
        check("b_gnt", 32'(b_gnt), 32'(m_gb));
        check("ram_wr_enb", 32'(ram_wr_enb), 32'(m_wr));
        check("ram_rd_enb", 32'(ram_rd_enb), 32'(m_rd));
        check("err_pulse", 32'(err_pulse), 32'(m_err));
        check("ram_addr", 32'(ram_addr), 32'(m_addr));
        check("ram_data_in", 32'(ram_data_in), 32'(m_din));
        resp = exp_q.pop_front();
        check("a_rvalid", 32'(a_rvalid), 32'(resp[RW-1]));
        check("b_rvalid", 32'(b_rvalid), 32'(resp[RW-2]));
        if (resp[RW-1] || resp[RW-2]) begin
            check("rerr", 32'(rerr), 32'(resp[W]));
            check("rdata", 32'(rdata), 32'(resp[W-1:0]));
        end
        m_wr = 1'b0; m_rd = 1'b0; m_err = 1'b0;
        entry = '0;
        if (m_ga || m_gb) begin
            p_we   = m_gb ? bw : aw;
            p_addr = m_gb ? ba : aa;
            p_wd   = m_gb ? bd : ad;
            m_last_b = m_gb;
            if (p_addr >= DEPTH) begin
                m_err = 1'b1;
                if (!p_we) entry = {m_ga, m_gb, 1'b1, {W{1'b0}}};
            end else if (p_we) begin
                m_wr = 1'b1; m_addr = p_addr; m_din = p_wd;
                ref_mem[p_addr[9:0]] = p_wd;
            end else begin
                m_rd = 1'b1; m_addr = p_addr;
                entry = {m_ga, m_gb, 1'b0, ref_mem[p_addr[9:0]]};
            end
        end
        exp_q.push_back(entry);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit ga, gb;
        for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, 0, '0, '0, ga, gb);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bit            ga, gb;
        logic [5:0]    a_seq, b_seq;
        int            na, nb;
        bit            pa_v, pa_we, pb_v, pb_we;
        logic [AW-1:0] pa_addr, pb_addr;
        logic [W-1:0]  pa_wd, pb_wd;

        rst_n = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b1; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // write 5 <- 0x2A5A5 from A, then B reads it back on the very next cycle
        cycle(1, 1, 11'd5, 22'h2A5A5, 0, 0, '0, '0, ga, gb);
        cycle(0, 0, '0, '0, 1, 0, 11'd5, '0, ga, gb);
        idle(3);

        // continuous contention: strict alternation starting with A
        a_seq = '0; b_seq = '0; na = 0; nb = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1, 1, 11'(100 + na), 22'(16'hBEE0 + na), 1, 0, 11'd5, '0, ga, gb);
            a_seq[i] = ga; b_seq[i] = gb;
            na += int'(ga); nb += int'(gb);
        end
        check("contend_a_seq", 32'(a_seq), 32'(6'b010101));
        check("contend_b_seq", 32'(b_seq), 32'(6'b101010));
        check("contend_a_cnt", 32'(na), 3);
        check("contend_b_cnt", 32'(nb), 3);
        idle(2);

        // illegal read address
        cycle(1, 0, 11'd1024, '0, 0, 0, '0, '0, ga, gb);
        check("illegal_rd_enb", 32'(ram_rd_enb), 0);
        check("illegal_err", 32'(err_pulse), 1);
        idle(1);
        cycle(0, 1, '0, '0, 1, 1, 11'd2047, 22'h3FFFF, ga, gb);
        idle(2);

        // reset lands while a B read is in flight
        cycle(0, 0, '0, '0, 1, 0, 11'd5, '0, ga, gb);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(4);
        cycle(1, 0, 11'd5, '0, 1, 0, 11'd5, '0, ga, gb);
        check("post_reset_a_first", 32'(ga), 1);
        idle(2);

        // full-depth streaming writes then reads
        for (int i = 0; i < DEPTH; i++) cycle(1, 1, 11'(i), 22'(i), 0, 0, '0, '0, ga, gb);
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, '0, '0, 1, 0, 11'(i), '0, ga, gb);
        idle(2);

        // random two-port traffic honouring the hold-until-granted rule
        pa_v = 0; pb_v = 0;
        pa_we = 0; pb_we = 0; pa_addr = '0; pb_addr = '0; pa_wd = '0; pb_wd = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!pa_v && $urandom_range(0, 99) < 60) begin
                pa_v = 1; pa_we = 1'($urandom_range(0, 1));
                pa_addr = 11'($urandom_range(0, 1039)); pa_wd = 22'($urandom);
            end
            if (!pb_v && $urandom_range(0, 99) < 60) begin
                pb_v = 1; pb_we = 1'($urandom_range(0, 1));
                pb_addr = 11'($urandom_range(0, 1039)); pb_wd = 22'($urandom);
            end
            cycle(pa_v, pa_we, pa_addr, pa_wd, pb_v, pb_we, pb_addr, pb_wd, ga, gb);
            if (m_ga) pa_v = 0;
            if (m_gb) pb_v = 0;
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
